// File: rtl/pool2_stream_tx.sv
// pool2_stream_tx: captures one pool2 feature-map frame into a shadow register
// and streams it out as WORD_W-bit words over a valid/ready interface.
module pool2_stream_tx #(
  parameter int unsigned NUM_CH   = 60,
  parameter int unsigned MAP_BITS = 16,
  parameter int unsigned WORD_W   = 16,
  localparam int unsigned FRAME_W   = NUM_CH * MAP_BITS,
  localparam int unsigned NUM_WORDS = FRAME_W / WORD_W,
  localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [0:FRAME_W-1] i_fmaps,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [WORD_W-1:0]  o_data,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_last,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_drop
);

  // Frame must split into whole words.
  if ((FRAME_W % WORD_W) != 0) begin : g_bad_word_w
    $error("pool2_stream_tx: NUM_CH*MAP_BITS must be a multiple of WORD_W");
  end

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e             state_q;
  logic [0:FRAME_W-1] shadow_q;
  logic [IDX_W-1:0]   idx_q;
  logic               valid_q;
  logic               last_q;
  logic               done_q;
  logic               drop_q;
  logic [IDX_W-1:0]   idx_nxt;

  assign idx_nxt = idx_q + IDX_W'(1);

  // The current word always sits at the head (bit 0) of the shadow; each
  // transfer shifts the next word into place, so no wide output mux is needed.
  assign o_data  = shadow_q[0:WORD_W-1];
  assign o_valid = valid_q;
  assign o_busy  = valid_q;
  assign o_idx   = idx_q;
  assign o_last  = last_q;
  assign o_done  = done_q;
  assign o_drop  = drop_q;

  // Capture/stream FSM with registered handshake and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_load) begin
            shadow_q <= i_fmaps;
            idx_q    <= '0;
            valid_q  <= 1'b1;
            last_q   <= (NUM_WORDS == 1);
            state_q  <= StSend;
          end
        end
        StSend: begin
          if (i_ready && last_q) begin
            done_q <= 1'b1;
            if (i_load) begin
              // Back-to-back frame: no bubble on o_valid.
              shadow_q <= i_fmaps;
              idx_q    <= '0;
              last_q   <= (NUM_WORDS == 1);
            end else begin
              idx_q   <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            if (i_ready) begin
              shadow_q <= shadow_q << WORD_W;
              idx_q    <= idx_nxt;
              last_q   <= (idx_nxt == LastIdx);
            end
            // A load that cannot be honoured is reported, never queued.
            if (i_load) begin
              drop_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pool2_stream_tx.sv
// Testbench for pool2_stream_tx: frame-level reference model with per-cycle
// comparison, plus directed scenarios with literal expectations.
module tb_pool2_stream_tx;

  localparam int NW = 60;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           i_load = 1'b0;
  logic [0:959]   i_fmaps = '0;
  logic           i_ready = 1'b0;

  logic           o_valid, o_last, o_busy, o_done, o_drop;
  logic [15:0]    o_data;
  logic [5:0]     o_idx;

  logic           v32, last32, busy32, done32, drop32;
  logic [31:0]    d32;
  logic [4:0]     idx32;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pool2_stream_tx #(.NUM_CH(60), .MAP_BITS(16), .WORD_W(16)) dut (
    .clk(clk), .rst(rst), .i_load(i_load), .i_fmaps(i_fmaps),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_idx(o_idx),
    .o_last(o_last), .o_busy(o_busy), .o_done(o_done), .o_drop(o_drop)
  );

  pool2_stream_tx #(.NUM_CH(60), .MAP_BITS(16), .WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .i_load(i_load), .i_fmaps(i_fmaps),
    .o_valid(v32), .i_ready(i_ready), .o_data(d32), .o_idx(idx32),
    .o_last(last32), .o_busy(busy32), .o_done(done32), .o_drop(drop32)
  );

  // ---------------- reference model (16-bit instance) ----------------
  logic [0:959] m_frame;
  bit           m_busy;
  int           m_idx;
  bit           m_done, m_drop;

  // Word k takes frame bits k*16..k*16+15, first bit landing in the MSB.
  function automatic logic [15:0] word_of(input logic [0:959] f, input int k);
    logic [15:0] w;
    for (int b = 0; b < 16; b++) w[15-b] = f[k*16+b];
    return w;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_idx = 0; m_done = 0; m_drop = 0; m_frame = '0;
    end else begin
      m_done = 0;
      m_drop = 0;
      if (!m_busy) begin
        if (i_load) begin m_frame = i_fmaps; m_idx = 0; m_busy = 1; end
      end else if (i_ready && m_idx == NW-1) begin
        m_done = 1;
        m_idx  = 0;
        if (i_load) m_frame = i_fmaps;
        else        m_busy = 0;
      end else begin
        if (i_ready) m_idx = m_idx + 1;
        if (i_load)  m_drop = 1;
      end
    end
  end

  // ---------------- per-cycle compare + receive log ----------------
  logic [15:0] rx[$];
  int busy_cnt = 0;
  int done_cnt = 0;
  int drop_cnt = 0;

  always @(negedge clk) begin
    logic        e_last;
    logic [5:0]  e_idx;
    logic [15:0] e_data;
    bit          bad;
    e_idx  = 6'(m_idx);
    e_last = m_busy && (m_idx == NW-1);
    e_data = word_of(m_frame, m_idx);
    bad = (o_valid !== m_busy) || (o_busy !== m_busy) || (o_idx !== e_idx) ||
          (o_last !== e_last) || (o_done !== m_done) || (o_drop !== m_drop) ||
          (m_busy && (o_data !== e_data));
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL cycle_model t=%0t act v=%b b=%b i=%0d l=%b d=%b dr=%b data=%h req v=%b i=%0d l=%b d=%b dr=%b data=%h",
               $time, o_valid, o_busy, o_idx, o_last, o_done, o_drop, o_data,
               m_busy, e_idx, e_last, m_done, m_drop, e_data);
    end
    if (o_busy) busy_cnt++;
    if (o_done) done_cnt++;
    if (o_drop) drop_cnt++;
    if (o_valid && i_ready) rx.push_back(o_data);
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [0:959] ramp_frame();
    logic [0:959] f;
    for (int c = 0; c < 60; c++) f[c*16 +: 16] = 16'(c + 1);
    return f;
  endfunction

  function automatic logic [0:959] fill_frame(input logic [15:0] v);
    logic [0:959] f;
    for (int c = 0; c < 60; c++) f[c*16 +: 16] = v;
    return f;
  endfunction

  task automatic clear_logs();
    rx.delete();
    busy_cnt = 0; done_cnt = 0; drop_cnt = 0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int bad;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_busy",  64'(o_busy),  64'd0);
    chk("rst_idx",   64'(o_idx),   64'd0);
    chk("rst_data",  64'(o_data),  64'd0);
    chk("rst_flags", 64'({o_last, o_done, o_drop}), 64'd0);
    rst = 1'b0;
    step();

    // 1: ramp frame, consumer always ready
    clear_logs();
    i_fmaps = ramp_frame(); i_ready = 1'b1; i_load = 1'b1;
    step();
    i_load = 1'b0; i_fmaps = '0;
    chk("t1_first_valid", 64'(o_valid), 64'd1);
    chk("t1_first_word",  64'({o_idx, o_data}), 64'({6'd0, 16'h0001}));
    repeat (59) step();
    chk("t1_last_word", 64'({o_last, o_idx, o_data}), 64'({1'b1, 6'd59, 16'h003C}));
    step();
    chk("t1_done_pulse", 64'({o_done, o_valid, o_busy}), 64'({1'b1, 1'b0, 1'b0}));
    step();
    chk("t1_done_clear", 64'(o_done), 64'd0);
    chk("t1_busy_cycles", 64'(busy_cnt), 64'd60);
    chk("t1_done_count", 64'(done_cnt), 64'd1);
    chk("t1_rx_count", 64'(rx.size()), 64'd60);
    chk("t1_rx_59", 64'(rx.size() == 60 ? rx[59] : 16'hxxxx), 64'h003C);

    // 2: same frame under random back-pressure
    clear_logs();
    i_fmaps = ramp_frame(); i_load = 1'b1;
    step();
    i_load = 1'b0;
    for (int n = 0; n < 300; n++) begin
      i_ready = 1'($urandom_range(0, 1));
      step();
    end
    i_ready = 1'b1;
    repeat (3) step();
    chk("t2_rx_count", 64'(rx.size()), 64'd60);
    bad = 0;
    for (int k = 0; k < rx.size(); k++) if (rx[k] !== 16'(k + 1)) bad++;
    chk("t2_order", 64'(bad), 64'd0);
    chk("t2_done_count", 64'(done_cnt), 64'd1);

    // 3: back-to-back frames A then B
    clear_logs();
    i_fmaps = ramp_frame(); i_load = 1'b1;
    step();
    i_load = 1'b0;
    repeat (59) step();
    i_fmaps = fill_frame(16'hA5A5); i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("t3_no_bubble", 64'({o_valid, o_idx, o_data}), 64'({1'b1, 6'd0, 16'hA5A5}));
    chk("t3_done_pulse", 64'(o_done), 64'd1);
    repeat (61) step();
    chk("t3_done_count", 64'(done_cnt), 64'd2);
    chk("t3_rx_count", 64'(rx.size()), 64'd120);
    bad = 0;
    for (int k = 60; k < rx.size(); k++) if (rx[k] !== 16'hA5A5) bad++;
    chk("t3_frame_b", 64'(bad), 64'd0);

    // 4: load during a frame is dropped
    clear_logs();
    i_fmaps = ramp_frame(); i_load = 1'b1;
    step();
    i_load = 1'b0;
    repeat (20) step();
    chk("t4_at_idx20", 64'(o_idx), 64'd20);
    i_fmaps = fill_frame(16'hFFFF); i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("t4_drop_pulse", 64'(o_drop), 64'd1);
    step();
    chk("t4_drop_clear", 64'(o_drop), 64'd0);
    repeat (42) step();
    chk("t4_drop_count", 64'(drop_cnt), 64'd1);
    chk("t4_rx_count", 64'(rx.size()), 64'd60);
    bad = 0;
    for (int k = 0; k < rx.size(); k++) if (rx[k] !== 16'(k + 1)) bad++;
    chk("t4_original", 64'(bad), 64'd0);

    // 5: reset in the middle of a frame
    clear_logs();
    i_fmaps = ramp_frame(); i_load = 1'b1;
    step();
    i_load = 1'b0;
    repeat (30) step();
    chk("t5_at_idx30", 64'(o_idx), 64'd30);
    #1 rst = 1'b1;
    #1;
    chk("t5_async_drop", 64'({o_valid, o_busy}), 64'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (2) step();
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    chk("t5_idle", 64'({o_valid, o_idx}), 64'd0);
    clear_logs();
    i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("t5_restart", 64'({o_valid, o_idx, o_data}), 64'({1'b1, 6'd0, 16'h0001}));
    repeat (61) step();
    chk("t5_done_after", 64'(done_cnt), 64'd1);

    // 6: bit order, 16- and 32-bit word widths
    clear_logs();
    i_fmaps = '0; i_fmaps[0] = 1'b1; i_load = 1'b1;
    step();
    i_load = 1'b0;
    chk("t6_w16_word0", 64'(o_data), 64'h8000);
    chk("t6_w32_word0", 64'({v32, idx32, d32}), 64'({1'b1, 5'd0, 32'h80000000}));
    repeat (28) step();
    chk("t6_w32_idx28", 64'({idx32, last32}), 64'({5'd28, 1'b0}));
    step();
    chk("t6_w32_idx29", 64'({idx32, last32, d32}), 64'({5'd29, 1'b1, 32'h0}));
    step();
    chk("t6_w32_done", 64'({done32, v32}), 64'({1'b1, 1'b0}));
    repeat (32) step();
    chk("t6_rx_count", 64'(rx.size()), 64'd60);
    bad = 0;
    for (int k = 1; k < rx.size(); k++) if (rx[k] !== 16'h0) bad++;
    chk("t6_rest_zero", 64'(bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool2_stream_tx.md
Name: pool2_stream_tx

Overview:
- Transmit side for the pool2 output bundle.
- Captures one 60-channel × 4×4 binary feature-map frame (960 bits) on a load strobe.
- Streams the frame out as fixed-width words over a valid/ready interface, toward the next layer or off-chip buffer.
- Decouples the wide parallel pooling stage from a narrow consumer, including consumer back-pressure.

Parameters:
- NUM_CH, 60, number of feature-map channels in a frame.
- MAP_BITS, 16, bits per channel map (4×4, 1 bit per pixel).
- WORD_W, 16, output word width. NUM_CH*MAP_BITS must be an integer multiple of WORD_W (checked by elaboration assertion).
- NUM_WORDS (local), NUM_CH*MAP_BITS/WORD_W = 60, words per frame.
- IDX_W (local), max(1, clog2(NUM_WORDS)) = 6, word index width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_load  in  1  frame-capture strobe.
- i_fmaps  in  [0:NUM_CH*MAP_BITS-1]  frame; channel c occupies bits [c*MAP_BITS : (c+1)*MAP_BITS-1].
- o_valid  out  1  o_data/o_idx/o_last are valid.
- i_ready  in  1  consumer accepts the current word.
- o_data  out  WORD_W  current word.
- o_idx  out  IDX_W  index of the current word within the frame.
- o_last  out  1  current word is word NUM_WORDS-1.
- o_busy  out  1  frame in flight (state SEND).
- o_done  out  1  one-cycle pulse after the last word is accepted.
- o_drop  out  1  one-cycle pulse when i_load is ignored.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; o_valid=0, o_idx=0, o_last=0, o_busy=0, o_done=0, o_drop=0, o_data=0.
  - Frame shadow register cleared.
- Registers: a NUM_CH*MAP_BITS shadow register holds the frame, so i_fmaps may change freely after capture.
- Word mapping: word k = shadow[k*WORD_W : (k+1)*WORD_W-1]. o_data[WORD_W-1] = shadow bit k*WORD_W (first pixel in MSB).
- States:
  - IDLE: on i_load → capture i_fmaps, idx=0, go to SEND.
  - SEND: o_valid=1 and o_busy=1 throughout.
- Latency: i_load sampled high in IDLE at edge t → o_valid=1 with word 0 and o_idx=0 from edge t+1.
- Handshake:
  - Transfer occurs on a rising edge where o_valid && i_ready.
  - While o_valid && !i_ready, o_data, o_idx and o_last hold stable.
  - o_valid never drops before the transfer completes.
  - i_ready is ignored in IDLE.
  - Transfer of word k<NUM_WORDS-1 → idx=k+1 next cycle.
- o_last = (o_idx == NUM_WORDS-1) && o_valid.
- Last transfer without i_load:
  - Next cycle: state=IDLE, o_valid=0, o_busy=0, o_idx=0, o_done=1 for exactly one cycle.
- Last transfer with i_load in the same cycle (back-to-back):
  - Capture new frame, stay in SEND, o_idx=0.
  - o_valid stays 1 with no bubble; o_done still pulses 1 cycle.
- i_load in SEND at any other time: ignored; shadow unchanged; o_drop=1 next cycle for one cycle.
- i_load held high across several cycles in IDLE: only the first edge captures; later edges while in SEND raise o_drop.
- Reset mid-frame: frame is abandoned immediately (asynchronously); no o_done; after release the block is idle awaiting i_load.
- WORD_W == NUM_CH*MAP_BITS (NUM_WORDS=1): word 0 is also last; o_last=1 whenever o_valid.

Test Plan:
1. Reset, then i_load with channel c map = 16'(c+1), i_ready=1 constantly:
   - o_valid rises 1 cycle after load.
   - Words 0..59 = 0x0001..0x003C on consecutive cycles.
   - o_last only on idx 59; o_done pulses the cycle after; o_busy high for exactly 60 cycles.
2. Same frame, i_ready toggling 1,0,0,1,… (random 50%):
   - o_data/o_idx stable during stalls; all 60 words received in order, none duplicated.
3. Back-to-back: assert i_load with frame B (all 0xA5A5) in the cycle word 59 of frame A transfers:
   - Next cycle o_valid=1, o_idx=0, o_data=0xA5A5, no gap.
   - o_done one pulse; B fully delivered.
4. i_load pulsed at idx 20 of an in-flight frame with different data:
   - o_drop one-cycle pulse; remaining words 20..59 still from the original frame.
5. Assert rst at idx 30 with i_ready=1:
   - o_valid/o_busy drop immediately; o_done never pulses.
   - After release, a new load streams from idx 0.
6. Bit order: load only fmaps bit 0 set, i_ready=1:
   - Word 0 = 0x8000; all other words 0.
   - With WORD_W=32: 30 words; word 0 = 0x80000000, o_last at idx 29.
